imem_responder: RTL and testbench

//  Instruction-side memory responder: the target end of the I-mem req/resp

---
 rtl/imem_responder_if.sv | 25 ++
 rtl/imem_responder.sv | 123 ++++++++++++
 tb/tb_imem_responder.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Instruction-memory request/response bundle between the fetch pipeline
// (master) and the on-chip instruction RAM responder (slave).
interface imem_responder_if;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [63:0] im_resp_rdata;
    logic        im_resp_valid;

    modport master (
        output im_req_addr,
        output im_req_valid,
        input  im_req_ready,
        input  im_resp_rdata,
        input  im_resp_valid
    );

    modport slave (
        input  im_req_addr,
        input  im_req_valid,
        output im_req_ready,
        output im_resp_rdata,
        output im_resp_valid
    );
endinterface

// File: rtl/imem_responder.sv
// Target end of the I-mem req/resp interface: 64-bit instruction RAM with
// programmable wait states, strictly in-order single-outstanding responses.
module imem_responder #(
    parameter int unsigned DEPTH_LOG2  = 14,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_responder_if.slave       im,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_index,
    input  logic [63:0]           ld_data
);

    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [63:0] SPAN       = 64'd8 << DEPTH_LOG2;
    localparam bit          HAS_WAIT   = (WAIT_STATES != 0);
    localparam logic [3:0]  CNT_RELOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("imem_responder: WAIT_STATES must be in 0..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic                   in_range_q, in_range_d;
    logic [63:0]            rdata_q;

    logic [63:0]            mem [DEPTH];

    logic [63:0]            req_off;
    logic                   req_in_range;
    logic [DEPTH_LOG2-1:0]  req_idx;
    logic                   accept;
    logic                   load_resp;
    logic [DEPTH_LOG2-1:0]  rd_idx;
    logic                   rd_in_range;

    // Offset wraps mod 2^64, so addresses below the base are rejected explicitly.
    assign req_off      = im.im_req_addr - BASE_ADDR;
    assign req_in_range = (im.im_req_addr >= BASE_ADDR) && (req_off < SPAN);
    assign req_idx      = req_off[DEPTH_LOG2+2:3];

    assign im.im_req_ready  = !rst && (state_q != ST_WAIT);
    assign im.im_resp_valid = (state_q == ST_RESP);
    assign im.im_resp_rdata = rdata_q;

    assign accept = im.im_req_valid && im.im_req_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;

        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    idx_d      = req_idx;
                    in_range_d = req_in_range;
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Entering RESP from WAIT reads the latched request; otherwise it is the one being accepted now.
    assign load_resp   = (state_d == ST_RESP);
    assign rd_idx      = (state_q == ST_WAIT) ? idx_q : req_idx;
    assign rd_in_range = (state_q == ST_WAIT) ? in_range_q : req_in_range;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            rdata_q    <= 64'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            if (load_resp) begin
                rdata_q <= rd_in_range ? mem[rd_idx] : 64'h0;
            end
        end
    end

    // NOTE: the RAM array is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ld_en && !rst) begin
            mem[ld_index] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: one instance with no wait states and
// one with three, driven by directed fetch and backdoor-load sequences.
module tb_imem_responder;

    localparam int          DL   = 14;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam int          WS_A = 0;
    localparam int          WS_B = 3;

    typedef struct {
        logic [63:0] data;
        int          cycle;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic          ld_en_a, ld_en_b;
    logic [DL-1:0] ld_index_a, ld_index_b;
    logic [63:0]   ld_data_a, ld_data_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_a   = 0;
    int busy_b   = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [63:0] ref_a[int];
    logic [63:0] ref_b[int];

    imem_responder_if if_a ();
    imem_responder_if if_b ();

    imem_responder #(
        .DEPTH_LOG2 (DL),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS_A),
        .INIT_FILE  ("")
    ) u_dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .im      (if_a),
        .ld_en   (ld_en_a),
        .ld_index(ld_index_a),
        .ld_data (ld_data_a)
    );

    imem_responder #(
        .DEPTH_LOG2 (DL),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS_B),
        .INIT_FILE  ("")
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .im      (if_b),
        .ld_en   (ld_en_b),
        .ld_index(ld_index_b),
        .ld_data (ld_data_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] exp_data(input logic [63:0] addr, input bit side_b);
        logic [63:0] off;
        int          idx;
        off = addr - BASE;
        if (addr < BASE || off >= (64'd8 << DL)) return 64'h0;
        idx = int'(off >> 3);
        if (side_b) return ref_b.exists(idx) ? ref_b[idx] : 64'h0;
        return ref_a.exists(idx) ? ref_a[idx] : 64'h0;
    endfunction

    // Request-side trackers: push expectations at each handshake, check ready, follow backdoor loads.
    always @(negedge clk) begin
        if (rst_a) begin
            check("ready_a_in_reset", 64'(if_a.im_req_ready), 64'd0);
            q_a.delete();
            busy_a = 0;
        end else begin
            if (busy_a > 0) begin
                check("ready_a_low_in_wait", 64'(if_a.im_req_ready), 64'd0);
                busy_a--;
            end else begin
                check("ready_a_high", 64'(if_a.im_req_ready), 64'd1);
            end
            if (if_a.im_req_valid && if_a.im_req_ready) begin
                q_a.push_back('{data: exp_data(if_a.im_req_addr, 1'b0), cycle: cyc + 1 + WS_A});
                busy_a = WS_A;
            end
            if (ld_en_a) ref_a[int'(ld_index_a)] = ld_data_a;
        end
    end

    always @(negedge clk) begin
        if (rst_b) begin
            check("ready_b_in_reset", 64'(if_b.im_req_ready), 64'd0);
            q_b.delete();
            busy_b = 0;
        end else begin
            if (busy_b > 0) begin
                check("ready_b_low_in_wait", 64'(if_b.im_req_ready), 64'd0);
                busy_b--;
            end else begin
                check("ready_b_high", 64'(if_b.im_req_ready), 64'd1);
            end
            if (if_b.im_req_valid && if_b.im_req_ready) begin
                q_b.push_back('{data: exp_data(if_b.im_req_addr, 1'b1), cycle: cyc + 1 + WS_B});
                busy_b = WS_B;
            end
            if (ld_en_b) ref_b[int'(ld_index_b)] = ld_data_b;
        end
    end

    // Response monitors.
    always @(negedge clk) begin
        exp_t e;
        if (if_a.im_resp_valid) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_a_unexpected: got rdata %h with no request pending (cycle %0d)",
                         if_a.im_resp_rdata, cyc);
            end else begin
                e = q_a.pop_front();
                check("resp_a_data", if_a.im_resp_rdata, e.data);
                check("resp_a_cycle", 64'(cyc), 64'(e.cycle));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if_b.im_resp_valid) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_b_unexpected: got rdata %h with no request pending (cycle %0d)",
                         if_b.im_resp_rdata, cyc);
            end else begin
                e = q_b.pop_front();
                check("resp_b_data", if_b.im_resp_rdata, e.data);
                check("resp_b_cycle", 64'(cyc), 64'(e.cycle));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit side_b, input logic [63:0] addr);
        int  waited;
        bit  rdy;
        waited = 0;
        if (side_b) begin
            if_b.im_req_valid = 1'b1;
            if_b.im_req_addr  = addr;
        end else begin
            if_a.im_req_valid = 1'b1;
            if_a.im_req_addr  = addr;
        end
        rdy = 1'b0;
        while (!rdy) begin
            @(negedge clk);
            rdy = side_b ? if_b.im_req_ready : if_a.im_req_ready;
            if (!rdy) begin
                waited++;
                if (waited > 50) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: ready still 0 after %0d cycles, expected 1 for addr %h",
                             waited, addr);
                    rdy = 1'b1;
                end
            end
        end
        step(1);
    endtask

    task automatic idle(input bit side_b);
        if (side_b) if_b.im_req_valid = 1'b0;
        else        if_a.im_req_valid = 1'b0;
    endtask

    task automatic load(input bit side_b, input logic [DL-1:0] idx, input logic [63:0] data);
        if (side_b) begin
            ld_en_b = 1'b1; ld_index_b = idx; ld_data_b = data;
        end else begin
            ld_en_a = 1'b1; ld_index_a = idx; ld_data_a = data;
        end
        step(1);
        ld_en_a = 1'b0;
        ld_en_b = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d responses outstanding, expected 0/0",
                     q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ld_en_a = 1'b0; ld_index_a = '0; ld_data_a = '0;
        ld_en_b = 1'b0; ld_index_b = '0; ld_data_b = '0;
        if_a.im_req_valid = 1'b0; if_a.im_req_addr = '0;
        if_b.im_req_valid = 1'b0; if_b.im_req_addr = '0;

        step(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("reset_rdata_a", if_a.im_resp_rdata, 64'h0);
        check("reset_valid_a", 64'(if_a.im_resp_valid), 64'd0);
        check("reset_rdata_b", if_b.im_resp_rdata, 64'h0);
        check("reset_valid_b", 64'(if_b.im_resp_valid), 64'd0);
        step(1);

        // Single fetch, zero wait states; the +4 half returns the same doubleword.
        load(1'b0, 0, 64'h0000_0013_0000_0093);
        send(1'b0, BASE);
        send(1'b0, BASE + 64'd4);
        idle(1'b0);
        drain();

        // Eight back-to-back fetches at full throughput.
        for (int k = 0; k < 8; k++) load(1'b0, DL'(k), {32'hC0DE_0000 + 32'(k), 32'(k * 7 + 1)});
        for (int k = 0; k < 8; k++) send(1'b0, BASE + 64'(8 * k));
        idle(1'b0);
        drain();

        // Range boundaries: below base, last word, one past the end.
        load(1'b0, '1, 64'hFEED_FACE_1234_5678);
        send(1'b0, 64'h0000_0000_7FFF_FFF8);
        send(1'b0, BASE + (64'd8 << DL) - 64'd8);
        send(1'b0, BASE + (64'd8 << DL));
        idle(1'b0);
        drain();

        // Backdoor write colliding with a response read of the same word.
        load(1'b0, 5, 64'h0101_0101_0101_0101);
        if_a.im_req_valid = 1'b1;
        if_a.im_req_addr  = BASE + 64'd40;
        ld_en_a = 1'b1; ld_index_a = 5; ld_data_a = 64'h2222_3333_4444_5555;
        step(1);
        idle(1'b0);
        ld_en_a = 1'b0;
        send(1'b0, BASE + 64'd40);
        idle(1'b0);
        drain();

        // Three wait states, requests held back-to-back.
        load(1'b1, 0, 64'hAAAA_0000_BBBB_0000);
        load(1'b1, 1, 64'h1111_2222_3333_4444);
        send(1'b1, BASE);
        send(1'b1, BASE + 64'd8);
        idle(1'b1);
        drain();

        // Reset mid-WAIT drops the request; a load during reset is ignored.
        send(1'b1, BASE + 64'd8);
        idle(1'b1);
        step(1);
        rst_b = 1'b1;
        ld_en_b = 1'b1; ld_index_b = 1; ld_data_b = 64'hDEAD_DEAD_DEAD_DEAD;
        step(1);
        rst_b = 1'b0;
        ld_en_b = 1'b0;
        @(negedge clk);
        check("rst_mid_rdata_b", if_b.im_resp_rdata, 64'h0);
        check("rst_mid_valid_b", 64'(if_b.im_resp_valid), 64'd0);
        step(10);
        send(1'b1, BASE + 64'd8);
        idle(1'b1);
        drain();

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
